tqvp_prism_aux: RTL and testbench

Parametrised auxiliary unit for the PRISM programmable-FSM peripheral on the TinyQV bus. It generalises the fixed countdown counter and 8/24-bit shifter into CHANNELS independent countdown counters, with optional auto-reload, and a variable-length bidirectional shift register. It adds sticky event flags with per-source interrupt enables. The FSM drives its strobe inputs and samples its status outputs; the CPU programs it through the peripheral register window.

---
 rtl/prism_aux_pkg.sv | 41 ++++
 rtl/prism_aux_counter.sv | 53 +++++
 rtl/tqvp_prism_aux.sv | 189 ++++++++++++++++++
 tb/tb_tqvp_prism_aux.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prism_aux_pkg.sv
// Shared register map, bit positions and helpers for the PRISM auxiliary unit
// (countdown counters, variable-length shifter, sticky event flags).
package prism_aux_pkg;

  // TinyQV data_write_n encodings; only full-word writes reach registers.
  typedef enum logic [1:0] {
    BUS_WR_BYTE = 2'b00,
    BUS_WR_HALF = 2'b01,
    BUS_WR_WORD = 2'b10,
    BUS_WR_IDLE = 2'b11
  } bus_wr_e;

  localparam logic [5:0] ADDR_CTRL       = 6'h00;
  localparam logic [5:0] ADDR_STATUS     = 6'h04;
  localparam logic [5:0] ADDR_SHIFT_DATA = 6'h08;
  localparam logic [5:0] ADDR_SHIFT_LEN  = 6'h0C;

  localparam int ADDR_CNT_BASE = 'h10;
  localparam int CNT_STRIDE    = 8;
  localparam int PRELOAD_OFS   = 0;
  localparam int COUNT_OFS     = 4;

  localparam int CTRL_SHIFT_DIR      = 0;
  localparam int CTRL_AUTORELOAD_LSB = 8;
  localparam int CTRL_ZERO_IE_LSB    = 16;
  localparam int CTRL_DONE_IE        = 24;

  localparam int STAT_ZERO_LSB = 0;
  localparam int STAT_DONE     = 8;

  function automatic logic [5:0] cnt_addr(input int ch, input int ofs);
    return 6'(ADDR_CNT_BASE + ch * CNT_STRIDE + ofs);
  endfunction

  // A programmed length of 0, or one wider than the register, means full width.
  function automatic logic [5:0] eff_len(input logic [5:0] len, input int width);
    if (len == 6'd0 || int'(len) > width) return 6'(width);
    return len;
  endfunction

endpackage

// File: rtl/prism_aux_counter.sv
// One countdown channel: preload and count registers, load/decrement with
// optional autoreload, and a single-cycle zero event on the 1 -> 0/reload step.
module prism_aux_counter
  import prism_aux_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exec,
  input  logic             load,
  input  logic             dec,
  input  logic             autoreload,
  input  logic             preload_we,
  input  logic             count_we,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] preload,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             zero_event
);

  logic dec_active;

  // A bus write to COUNT pre-empts the FSM strobes, including the event.
  assign dec_active = exec && !load && dec && !count_we;
  assign zero_event = dec_active && (count == CNT_W'(1));
  assign zero       = (count == '0);

  // NOTE: registers use non-blocking assignment so every channel samples the
  // same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      preload <= '0;
      count   <= '0;
    end else begin
      if (preload_we) preload <= wdata;

      if (count_we) begin
        count <= wdata;
      end else if (exec && load) begin
        count <= preload;
      end else if (dec_active) begin
        if (count > CNT_W'(1)) begin
          count <= count - CNT_W'(1);
        end else if (count == CNT_W'(1)) begin
          count <= autoreload ? preload : '0;
        end
      end
    end
  end

endmodule

// File: rtl/tqvp_prism_aux.sv
// PRISM auxiliary unit: CHANNELS countdown counters, a bidirectional shifter
// of programmable length and sticky interrupt flags on the TinyQV bus.
// Optional feature macro: PRISM_AUX_AUTORELOAD_EN (per-channel autoreload).
module tqvp_prism_aux
  import prism_aux_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 24,
  parameter int SHIFT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          address,
  input  logic [31:0]         data_in,
  input  logic [1:0]          data_write_n,
  input  logic [1:0]          data_read_n,
  output logic [31:0]         data_out,
  output logic                data_ready,
  output logic                user_interrupt,
  input  logic                exec,
  input  logic [CHANNELS-1:0] cnt_load,
  input  logic [CHANNELS-1:0] cnt_dec,
  input  logic                shift_en,
  input  logic                shift_in,
  output logic [CHANNELS-1:0] cnt_zero,
  output logic                shift_out,
  output logic                shift_done
);

  // Reads have no side effects, and not every data_in bit maps to a register.
  logic unused_ok;
  assign unused_ok  = &{1'b0, data_read_n, data_in};
  assign data_ready = 1'b1;

  logic wr_en, ctrl_we, status_we, sdata_we, slen_we;
  logic [CHANNELS-1:0] preload_we, count_we;

  assign wr_en     = (bus_wr_e'(data_write_n) == BUS_WR_WORD);
  assign ctrl_we   = wr_en && (address == ADDR_CTRL);
  assign status_we = wr_en && (address == ADDR_STATUS);
  assign sdata_we  = wr_en && (address == ADDR_SHIFT_DATA);
  assign slen_we   = wr_en && (address == ADDR_SHIFT_LEN);

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    preload_we = '0;
    count_we   = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      preload_we[ch] = wr_en && (address == cnt_addr(ch, PRELOAD_OFS));
      count_we[ch]   = wr_en && (address == cnt_addr(ch, COUNT_OFS));
    end
  end

  logic                ctrl_dir, ctrl_done_ie;
  logic [CHANNELS-1:0] ctrl_zero_ie, ctrl_autoreload;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_dir     <= 1'b0;
      ctrl_zero_ie <= '0;
      ctrl_done_ie <= 1'b0;
    end else if (ctrl_we) begin
      ctrl_dir     <= data_in[CTRL_SHIFT_DIR];
      ctrl_zero_ie <= data_in[CTRL_ZERO_IE_LSB +: CHANNELS];
      ctrl_done_ie <= data_in[CTRL_DONE_IE];
    end
  end

`ifdef PRISM_AUX_AUTORELOAD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_autoreload <= '0;
    end else if (ctrl_we) begin
      ctrl_autoreload <= data_in[CTRL_AUTORELOAD_LSB +: CHANNELS];
    end
  end
`else
  assign ctrl_autoreload = '0;
`endif

  logic [CNT_W-1:0]    preload_q [CHANNELS];
  logic [CNT_W-1:0]    count_q   [CHANNELS];
  logic [CHANNELS-1:0] zero_event;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_cnt
    prism_aux_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .exec       (exec),
      .load       (cnt_load[ch]),
      .dec        (cnt_dec[ch]),
      .autoreload (ctrl_autoreload[ch]),
      .preload_we (preload_we[ch]),
      .count_we   (count_we[ch]),
      .wdata      (data_in[CNT_W-1:0]),
      .preload    (preload_q[ch]),
      .count      (count_q[ch]),
      .zero       (cnt_zero[ch]),
      .zero_event (zero_event[ch])
    );
  end

  logic [5:0]         shift_len, shift_l, new_l, bit_cnt, bit_next;
  logic [SHIFT_W-1:0] sr, l_mask, new_mask, msb_bit, sr_shifted;
  logic               shift_fire, frame_end, done_event;

  assign shift_l  = eff_len(shift_len, SHIFT_W);
  assign new_l    = eff_len(data_in[5:0], SHIFT_W);
  assign l_mask   = ~({SHIFT_W{1'b1}} << shift_l);
  assign new_mask = ~({SHIFT_W{1'b1}} << new_l);
  assign msb_bit  = l_mask ^ (l_mask >> 1);

  // Active bits sit in sr[L-1:0]; the rest stay zero so both directions
  // only need the L mask and the one-hot of bit L-1.
  assign sr_shifted = ctrl_dir ? ((sr >> 1) | (shift_in ? msb_bit : '0))
                               : (((sr << 1) | SHIFT_W'(shift_in)) & l_mask);

  assign shift_fire = exec && shift_en && !sdata_we && !slen_we;
  assign bit_next   = bit_cnt + 6'd1;
  assign frame_end  = (bit_next == shift_l);
  assign done_event = shift_fire && frame_end;
  assign shift_out  = ctrl_dir ? sr[0] : |(sr & msb_bit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr         <= '0;
      shift_len  <= '0;
      bit_cnt    <= '0;
      shift_done <= 1'b0;
    end else if (sdata_we) begin
      sr         <= data_in[SHIFT_W-1:0] & l_mask;
      bit_cnt    <= '0;
      shift_done <= 1'b0;
    end else if (slen_we) begin
      shift_len <= data_in[5:0];
      sr        <= sr & new_mask;
      bit_cnt   <= '0;
    end else if (shift_fire) begin
      sr         <= sr_shifted;
      bit_cnt    <= frame_end ? 6'd0 : bit_next;
      shift_done <= frame_end;
    end
  end

  logic [CHANNELS-1:0] zero_flag, zero_clr;
  logic                done_flag, done_clr;

  assign zero_clr = status_we ? data_in[STAT_ZERO_LSB +: CHANNELS] : '0;
  assign done_clr = status_we && data_in[STAT_DONE];

  // A new event wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_flag <= '0;
      done_flag <= 1'b0;
    end else begin
      zero_flag <= (zero_flag & ~zero_clr) | zero_event;
      done_flag <= (done_flag & ~done_clr) | done_event;
    end
  end

  assign user_interrupt = (|(zero_flag & ctrl_zero_ie)) | (done_flag & ctrl_done_ie);

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL: begin
        data_out[CTRL_SHIFT_DIR]                    = ctrl_dir;
        data_out[CTRL_AUTORELOAD_LSB +: CHANNELS]   = ctrl_autoreload;
        data_out[CTRL_ZERO_IE_LSB +: CHANNELS]      = ctrl_zero_ie;
        data_out[CTRL_DONE_IE]                      = ctrl_done_ie;
      end
      ADDR_STATUS: begin
        data_out[STAT_ZERO_LSB +: CHANNELS] = zero_flag;
        data_out[STAT_DONE]                 = done_flag;
      end
      ADDR_SHIFT_DATA: data_out[SHIFT_W-1:0] = sr;
      ADDR_SHIFT_LEN:  data_out[5:0]         = shift_len;
      default: begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          if (address == cnt_addr(ch, PRELOAD_OFS)) data_out[CNT_W-1:0] = preload_q[ch];
          if (address == cnt_addr(ch, COUNT_OFS))   data_out[CNT_W-1:0] = count_q[ch];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_tqvp_prism_aux.sv
// Self-checking bench for tqvp_prism_aux: directed scenarios plus random
// stimulus against an arithmetic reference model of the register behaviour.
module tb_tqvp_prism_aux;

  localparam int CH      = 2;
  localparam int CNT_W   = 24;
  localparam int SHIFT_W = 8;
`ifdef PRISM_AUX_AUTORELOAD_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    address;
  logic [31:0]   data_in;
  logic [1:0]    data_write_n;
  logic [1:0]    data_read_n;
  logic [31:0]   data_out;
  logic          data_ready;
  logic          user_interrupt;
  logic          exec;
  logic [CH-1:0] cnt_load, cnt_dec;
  logic          shift_en, shift_in;
  logic [CH-1:0] cnt_zero;
  logic          shift_out, shift_done;

  always #5 clk = ~clk;

  tqvp_prism_aux #(.CHANNELS(CH), .CNT_W(CNT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt),
    .exec           (exec),
    .cnt_load       (cnt_load),
    .cnt_dec        (cnt_dec),
    .shift_en       (shift_en),
    .shift_in       (shift_in),
    .cnt_zero       (cnt_zero),
    .shift_out      (shift_out),
    .shift_done     (shift_done)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state, held as plain integers.
  longint        m_pre [CH];
  longint        m_cnt [CH];
  longint        m_sr;
  int            m_len, m_bc;
  bit            m_dir, m_die, m_done;
  bit [CH-1:0]   m_ar, m_zie;
  bit [8:0]      m_flags;

  function automatic int eff_len(input int len);
    return (len == 0 || len > SHIFT_W) ? SHIFT_W : len;
  endfunction

  function automatic void model_reset();
    for (int ch = 0; ch < CH; ch++) begin
      m_pre[ch] = 0;
      m_cnt[ch] = 0;
    end
    m_sr = 0; m_len = 0; m_bc = 0;
    m_dir = 0; m_die = 0; m_done = 0;
    m_ar = '0; m_zie = '0; m_flags = '0;
  endfunction

  // Applies one clock edge of the rules to the model, using current inputs.
  function automatic void model_clock();
    bit       wr;
    int       l;
    bit [8:0] ev;
    longint   cmod, nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr   = (data_write_n == 2'b10);
    l    = eff_len(m_len);
    ev   = '0;
    cmod = longint'(1) << CNT_W;
    for (int ch = 0; ch < CH; ch++) begin
      nxt = m_cnt[ch];
      if (wr && address == 6'(20 + 8 * ch)) nxt = longint'(data_in) % cmod;
      else if (exec && cnt_load[ch]) nxt = m_pre[ch];
      else if (exec && cnt_dec[ch] && m_cnt[ch] > 1) nxt = m_cnt[ch] - 1;
      else if (exec && cnt_dec[ch] && m_cnt[ch] == 1) begin
        ev[ch] = 1'b1;
        nxt = (AR_EN && m_ar[ch]) ? m_pre[ch] : 0;
      end
      m_cnt[ch] = nxt;
      if (wr && address == 6'(16 + 8 * ch)) m_pre[ch] = longint'(data_in) % cmod;
    end
    if (wr && address == 6'h08) begin
      m_sr = longint'(data_in) % (longint'(1) << l);
      m_bc = 0; m_done = 0;
    end else if (wr && address == 6'h0C) begin
      m_len = int'(data_in[5:0]);
      m_bc  = 0;
      m_sr  = m_sr % (longint'(1) << eff_len(m_len));
    end else if (exec && shift_en) begin
      if (m_dir) m_sr = m_sr / 2 + longint'(shift_in) * (longint'(1) << (l - 1));
      else       m_sr = (m_sr * 2 + longint'(shift_in)) % (longint'(1) << l);
      m_bc++;
      if (m_bc == l) begin
        m_bc = 0; m_done = 1; ev[8] = 1'b1;
      end else begin
        m_done = 0;
      end
    end
    if (wr && address == 6'h00) begin
      m_dir = data_in[0];
      for (int ch = 0; ch < CH; ch++) begin
        m_ar[ch]  = AR_EN && data_in[8 + ch];
        m_zie[ch] = data_in[16 + ch];
      end
      m_die = data_in[24];
    end
    if (wr && address == 6'h04) m_flags = m_flags & ~data_in[8:0];
    m_flags = m_flags | ev;
  endfunction

  function automatic logic [CH+2:0] exp_outs();
    logic [CH-1:0] z;
    bit            irq;
    int            l;
    bit            so;
    l   = eff_len(m_len);
    irq = m_flags[8] && m_die;
    for (int ch = 0; ch < CH; ch++) begin
      z[ch] = (m_cnt[ch] == 0);
      irq   = irq || (m_flags[ch] && m_zie[ch]);
    end
    so = m_dir ? m_sr[0] : (((m_sr >> (l - 1)) & 1) != 0);
    return {z, so, m_done, irq};
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      6'h00: begin
        r[0] = m_dir;
        for (int ch = 0; ch < CH; ch++) begin
          r[8 + ch]  = m_ar[ch];
          r[16 + ch] = m_zie[ch];
        end
        r[24] = m_die;
      end
      6'h04: r[8:0] = m_flags;
      6'h08: r = 32'(m_sr);
      6'h0C: r = 32'(m_len);
      default: begin
        for (int ch = 0; ch < CH; ch++) begin
          if (a == 6'(16 + 8 * ch)) r = 32'(m_pre[ch]);
          if (a == 6'(20 + 8 * ch)) r = 32'(m_cnt[ch]);
        end
      end
    endcase
    return r;
  endfunction

  // One clock: model sees the driven inputs, then inputs return to idle.
  task automatic cycle();
    model_clock();
    @(posedge clk);
    #1;
    data_write_n = 2'b11;
    exec = 1'b0; cnt_load = '0; cnt_dec = '0;
    shift_en = 1'b0; shift_in = 1'b0; rst_n = 1'b1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    address = a; data_in = d; data_write_n = 2'b10;
    cycle();
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  task automatic test_reset();
    logic [5:0]  addrs [7] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h1C};
    logic [31:0] v;
    vectors++;
    if ({cnt_zero, shift_out, shift_done, user_interrupt} !== {2'b11, 3'b000}) begin
      $display("FAIL reset_outs got=%b want=%b", {cnt_zero, shift_out, shift_done, user_interrupt}, {2'b11, 3'b000});
      miscompares++;
    end
    vectors++;
    if (data_ready !== 1'b1) begin
      $display("FAIL data_ready got=%b want=1", data_ready);
      miscompares++;
    end
    foreach (addrs[i]) begin
      bus_read(addrs[i], v);
      vectors++;
      if (v !== 32'h0) begin
        $display("FAIL reset_reg[%h] got=%h want=0", addrs[i], v);
        miscompares++;
      end
    end
  endtask

  task automatic test_count_basic();
    int          exp_cnt [4] = '{2, 1, 0, 0};
    logic [31:0] v;
    bus_write(6'h10, 32'd3);
    exec = 1'b1; cnt_load = 2'b01;
    cycle();
    bus_read(6'h14, v);
    vectors++;
    if (v !== 32'd3) begin
      $display("FAIL cnt_load got=%0d want=3", v);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      exec = 1'b1; cnt_dec = 2'b01;
      cycle();
      bus_read(6'h14, v);
      vectors++;
      if (v !== 32'(exp_cnt[i])) begin
        $display("FAIL cnt_dec%0d got=%0d want=%0d", i, v, exp_cnt[i]);
        miscompares++;
      end
      bus_read(6'h04, v);
      vectors++;
      if ({v[0], cnt_zero[0]} !== {2{1'b1 & (i >= 2)}}) begin
        $display("FAIL cnt_flag%0d got=%b want=%b", i, {v[0], cnt_zero[0]}, {2{1'b1 & (i >= 2)}});
        miscompares++;
      end
    end
  endtask

  task automatic test_autoreload();
    int          exp_ar [4] = '{1, 2, 1, 2};
    int          exp_na [4] = '{1, 0, 0, 0};
    logic [31:0] v;
    int          want;
    bus_write(6'h04, 32'h1FF);
    bus_write(6'h00, 32'h0002_0200);
    bus_read(6'h00, v);
    vectors++;
    if (v !== (AR_EN ? 32'h0002_0200 : 32'h0002_0000)) begin
      $display("FAIL ctrl_readback got=%h want=%h", v, AR_EN ? 32'h0002_0200 : 32'h0002_0000);
      miscompares++;
    end
    bus_write(6'h18, 32'd2);
    exec = 1'b1; cnt_load = 2'b10;
    cycle();
    for (int i = 0; i < 4; i++) begin
      exec = 1'b1; cnt_dec = 2'b10;
      cycle();
      want = AR_EN ? exp_ar[i] : exp_na[i];
      bus_read(6'h1C, v);
      vectors++;
      if (v !== 32'(want)) begin
        $display("FAIL ar_count%0d got=%0d want=%0d", i, v, want);
        miscompares++;
      end
      vectors++;
      if (user_interrupt !== ((i == 1) || (i == 3 && AR_EN))) begin
        $display("FAIL ar_irq%0d got=%b want=%b", i, user_interrupt, (i == 1) || (i == 3 && AR_EN));
        miscompares++;
      end
      if (i == 1 || i == 3) begin
        bus_write(6'h04, 32'h2);
        vectors++;
        if (user_interrupt !== 1'b0) begin
          $display("FAIL ar_w1c%0d got=%b want=0", i, user_interrupt);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_shift_msb();
    bit          bits   [5] = '{1, 0, 1, 1, 0};
    int          exp_sr [5] = '{'h01, 'h02, 'h05, 'h0B, 'h16};
    logic [31:0] v;
    bus_write(6'h00, 32'h0);
    bus_write(6'h0C, 32'd5);
    bus_write(6'h08, 32'h0);
    for (int i = 0; i < 5; i++) begin
      exec = 1'b1; shift_en = 1'b1; shift_in = bits[i];
      cycle();
      bus_read(6'h08, v);
      vectors++;
      if ({v, shift_out, shift_done} !== {32'(exp_sr[i]), (i == 4), (i == 4)}) begin
        $display("FAIL msb_shift%0d got sr=%h out=%b done=%b want sr=%h out=%b done=%b",
                 i, v, shift_out, shift_done, exp_sr[i], i == 4, i == 4);
        miscompares++;
      end
    end
  endtask

  task automatic test_shift_lsb();
    bit          exp_out [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [31:0] v;
    bus_write(6'h00, 32'h1);
    bus_write(6'h0C, 32'd8);
    bus_write(6'h08, 32'hA5);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (shift_out !== exp_out[i]) begin
        $display("FAIL lsb_out%0d got=%b want=%b", i, shift_out, exp_out[i]);
        miscompares++;
      end
      exec = 1'b1; shift_en = 1'b1; shift_in = 1'b0;
      cycle();
    end
    bus_read(6'h08, v);
    vectors++;
    if ({v, shift_done} !== {32'h0, 1'b1}) begin
      $display("FAIL lsb_end got sr=%h done=%b want sr=0 done=1", v, shift_done);
      miscompares++;
    end
    exec = 1'b1; shift_en = 1'b1; shift_in = 1'b1;
    cycle();
    bus_read(6'h08, v);
    vectors++;
    if ({v, shift_done, shift_out} !== {32'h80, 2'b00}) begin
      $display("FAIL lsb_next got sr=%h done=%b out=%b want sr=80 done=0 out=0", v, shift_done, shift_out);
      miscompares++;
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    bus_write(6'h10, 32'd7);
    exec = 1'b1; cnt_load = 2'b01; cnt_dec = 2'b01;
    cycle();
    bus_read(6'h14, v);
    vectors++;
    if (v !== 32'd7) begin
      $display("FAIL load_vs_dec got=%0d want=7", v);
      miscompares++;
    end
    address = 6'h14; data_in = 32'h55; data_write_n = 2'b10;
    exec = 1'b1; cnt_load = 2'b01;
    cycle();
    bus_read(6'h14, v);
    vectors++;
    if (v !== 32'h55) begin
      $display("FAIL write_vs_load got=%h want=55", v);
      miscompares++;
    end
    bus_write(6'h14, 32'd1);
    bus_write(6'h04, 32'h1FF);
    bus_read(6'h04, v);
    vectors++;
    if (v !== 32'h0) begin
      $display("FAIL status_clear got=%h want=0", v);
      miscompares++;
    end
    address = 6'h04; data_in = 32'h1; data_write_n = 2'b10;
    exec = 1'b1; cnt_dec = 2'b01;
    cycle();
    bus_read(6'h04, v);
    vectors++;
    if (v[0] !== 1'b1) begin
      $display("FAIL event_vs_w1c got=%b want=1", v[0]);
      miscompares++;
    end
  endtask

  task automatic test_exec_gate();
    logic [31:0] v;
    bus_write(6'h14, 32'd4);
    bus_write(6'h08, 32'h3C);
    for (int i = 0; i < 5; i++) begin
      exec = 1'b0; cnt_load = '1; cnt_dec = '1; shift_en = 1'b1; shift_in = 1'b1;
      cycle();
    end
    bus_read(6'h14, v);
    vectors++;
    if (v !== 32'd4) begin
      $display("FAIL gate_count got=%0d want=4", v);
      miscompares++;
    end
    bus_read(6'h08, v);
    vectors++;
    if (v !== 32'h3C) begin
      $display("FAIL gate_sr got=%h want=3c", v);
      miscompares++;
    end
    vectors++;
    if ({cnt_zero, shift_out, shift_done, user_interrupt} !== exp_outs()) begin
      $display("FAIL gate_outs got=%b want=%b", {cnt_zero, shift_out, shift_done, user_interrupt}, exp_outs());
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [5:0]  waddrs [8] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C};
    logic [5:0]  ra;
    logic [31:0] v, want;
    for (int n = 0; n < 400; n++) begin
      exec     = ($urandom_range(0, 3) != 0);
      cnt_load = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      cnt_dec  = CH'($urandom);
      shift_en = $urandom_range(0, 1) == 1;
      shift_in = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 5) == 0) begin
        address = waddrs[$urandom_range(0, 7)];
        data_in = (address >= 6'h10) ? 32'($urandom_range(0, 6)) : $urandom;
        data_write_n = 2'b10;
      end else begin
        address = 6'($urandom);
        data_in = $urandom;
        data_write_n = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'b11;
      end
      cycle();
      vectors++;
      if ({cnt_zero, shift_out, shift_done, user_interrupt} !== exp_outs()) begin
        $display("FAIL rand_outs@%0d got=%b want=%b", n, {cnt_zero, shift_out, shift_done, user_interrupt}, exp_outs());
        miscompares++;
      end
      ra = ($urandom_range(0, 1) == 1) ? waddrs[$urandom_range(0, 7)] : 6'($urandom);
      bus_read(ra, v);
      want = model_read(ra);
      vectors++;
      if (v !== want) begin
        $display("FAIL rand_read@%0d addr=%h got=%h want=%h", n, ra, v, want);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0]  addrs [8] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C};
    logic [31:0] v;
    bus_write(6'h00, 32'h0103_0301);
    bus_write(6'h0C, 32'd6);
    bus_write(6'h18, 32'd9);
    for (int i = 0; i < 3; i++) begin
      exec = 1'b1; shift_en = 1'b1; shift_in = 1'b1; cnt_load = 2'b10;
      cycle();
    end
    rst_n = 1'b0; exec = 1'b1; cnt_load = '1; cnt_dec = '1; shift_en = 1'b1;
    address = 6'h00; data_in = 32'hFFFF_FFFF; data_write_n = 2'b10;
    cycle();
    vectors++;
    if ({cnt_zero, shift_out, shift_done, user_interrupt} !== {2'b11, 3'b000}) begin
      $display("FAIL midreset_outs got=%b want=%b", {cnt_zero, shift_out, shift_done, user_interrupt}, {2'b11, 3'b000});
      miscompares++;
    end
    foreach (addrs[i]) begin
      bus_read(addrs[i], v);
      vectors++;
      if (v !== 32'h0) begin
        $display("FAIL midreset_reg[%h] got=%h want=0", addrs[i], v);
        miscompares++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      exec = 1'b1; shift_en = 1'b1; shift_in = 1'b0;
      cycle();
      vectors++;
      if (shift_done !== (i == 7)) begin
        $display("FAIL midreset_frame%0d got=%b want=%b", i, shift_done, i == 7);
        miscompares++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; address = '0; data_in = '0; data_write_n = 2'b11; data_read_n = 2'b11;
    exec = 1'b0; cnt_load = '0; cnt_dec = '0; shift_en = 1'b0; shift_in = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b0;
    cycle();
    test_reset();
    test_count_basic();
    test_autoreload();
    test_shift_msb();
    test_shift_lsb();
    test_simultaneous();
    test_exec_gate();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
